// File: rtl/fp_align_add_pkg.sv
// Shared widths, constants and FSM state encoding for the binary32 align/add front end.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 24;
    localparam int SUM_W  = 25;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam logic [EXP_W-1:0] ALIGN_MAX   = 8'd25;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;
endpackage

// File: rtl/fp_align_add_if.sv
// Operand/result bus with valid/ready on both sides; master is the producer/consumer, slave is the adder.
interface fp_align_add_if;
    import fp_pkg::*;

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] result;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic             out_zero;
    logic             out_special;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, result, e, sign, out_zero, out_special
    );

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, result, e, sign, out_zero, out_special
    );
endinterface

// File: rtl/fp_align_add_unpack.sv
// Splits a binary32 word into sign, effective exponent, significand with hidden bit, and Inf/NaN flag.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]      word,
    output logic             sign,
    output logic [EXP_W-1:0] exp_eff,
    output logic [SIG_W-1:0] sig,
    output logic             is_special
);
    logic             hidden;
    logic [EXP_W-1:0] exp_raw;

    assign exp_raw    = word[30:23];
    assign hidden     = (exp_raw != '0);
    assign sign       = word[31];
    // Subnormals share the scale of exponent 1.
    assign exp_eff    = hidden ? exp_raw : 8'd1;
    assign sig        = {hidden, word[FRAC_W-1:0]};
    assign is_special = (exp_raw == EXP_SPECIAL);
endmodule

// File: rtl/fp_align_add.sv
// Orders two binary32 operands, serially aligns the smaller significand, then adds/subtracts magnitudes.
module fp_align_add
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp_align_add_if.slave  bus,
    output state_t         dbg_state
);
    logic             a_sign, b_sign, a_spec, b_spec;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic [31:0]      b_eff;

    assign b_eff = {bus.b[31] ^ bus.op_sub, bus.b[30:0]};

    fp_unpack u_unpack_a (.word(bus.a), .sign(a_sign), .exp_eff(a_exp), .sig(a_sig), .is_special(a_spec));
    fp_unpack u_unpack_b (.word(b_eff), .sign(b_sign), .exp_eff(b_exp), .sig(b_sig), .is_special(b_spec));

    // Magnitude order on the raw {exp, frac} bits; ties keep A as the larger operand.
    logic             a_big;
    logic             l_sign, s_sign, any_special;
    logic [EXP_W-1:0] l_exp, s_exp, diff;
    logic [SIG_W-1:0] l_sig, s_sig;

    assign a_big       = (bus.a[30:0] >= bus.b[30:0]);
    assign l_sign      = a_big ? a_sign : b_sign;
    assign s_sign      = a_big ? b_sign : a_sign;
    assign l_exp       = a_big ? a_exp  : b_exp;
    assign s_exp       = a_big ? b_exp  : a_exp;
    assign l_sig       = a_big ? a_sig  : b_sig;
    assign s_sig       = a_big ? b_sig  : a_sig;
    assign diff        = l_exp - s_exp;
    assign any_special = a_spec | b_spec;

    state_t           state;
    logic [SIG_W-1:0] m_l, m_s;
    logic [EXP_W-1:0] e_l;
    logic             sign_l, eff_sub, special;
    logic [4:0]       cnt;
    logic [SUM_W-1:0] sum;

    // L >= S by construction, so the subtraction cannot wrap.
    assign sum       = eff_sub ? ({1'b0, m_l} - {1'b0, m_s}) : ({1'b0, m_l} + {1'b0, m_s});
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.e           <= '0;
            bus.sign        <= 1'b0;
            bus.out_zero    <= 1'b0;
            bus.out_special <= 1'b0;
            m_l             <= '0;
            m_s             <= '0;
            e_l             <= '0;
            sign_l          <= 1'b0;
            eff_sub         <= 1'b0;
            special         <= 1'b0;
            cnt             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        m_l          <= l_sig;
                        e_l          <= l_exp;
                        sign_l       <= l_sign;
                        eff_sub      <= l_sign ^ s_sign;
                        special      <= any_special;
                        cnt          <= diff[4:0];
                        // Specials and out-of-range shifts skip alignment entirely.
                        if (any_special || diff >= ALIGN_MAX) begin
                            m_s   <= '0;
                            state <= ADD;
                        end else begin
                            m_s   <= s_sig;
                            state <= (diff == '0) ? ADD : ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    m_s <= m_s >> 1;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) state <= ADD;
                end
                ADD: begin
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                    if (special) begin
                        bus.result      <= '0;
                        bus.e           <= EXP_SPECIAL;
                        bus.sign        <= 1'b0;
                        bus.out_zero    <= 1'b0;
                        bus.out_special <= 1'b1;
                    end else begin
                        bus.result      <= sum;
                        bus.e           <= e_l;
                        bus.sign        <= (sum == '0) ? 1'b0 : sign_l;
                        bus.out_zero    <= (sum == '0);
                        bus.out_special <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_add.sv
// Randomised and directed bench for fp_align_add against a plain-arithmetic binary32 align/add model.
module tb_fp_align_add;
    import fp_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_fail   = 0;

    fp_align_add_if bus();

    fp_align_add dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

    always #5 clk = ~clk;

    // {special, zero, sign, e[7:0], result[24:0]} plus latency, in issue order.
    logic [35:0] exp_q[$];
    int          lat_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [35:0] packed_out, output int lat);
        int     ea, eb, el, es, d;
        longint ma, mb, ml, ms, rv;
        bit     sa, sb, sl, ss;
        logic [24:0] r;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            packed_out = {1'b1, 1'b0, 1'b0, 8'hFF, 25'd0};
            lat = 2;
            return;
        end
        ma = (ea != 0) ? (longint'(1) << 23) + longint'(a[22:0]) : longint'(a[22:0]);
        mb = (eb != 0) ? (longint'(1) << 23) + longint'(b[22:0]) : longint'(b[22:0]);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        if (a[30:0] >= b[30:0]) begin
            ml = ma; ms = mb; el = ea; es = eb; sl = sa; ss = sb;
        end else begin
            ml = mb; ms = ma; el = eb; es = ea; sl = sb; ss = sa;
        end
        d  = el - es;
        ms = (d >= 40) ? 0 : (ms >> d);
        rv = (sl != ss) ? ml - ms : ml + ms;
        r  = rv[24:0];
        packed_out = {1'b0, (rv == 0), (rv == 0) ? 1'b0 : sl, 8'(el), r};
        lat = (d >= 25) ? 2 : d + 2;
    endfunction

    task automatic expect_outputs(input string tag, input logic [35:0] x);
        check({tag, "_result"},  32'(bus.result),      32'(x[24:0]));
        check({tag, "_e"},       32'(bus.e),           32'(x[32:25]));
        check({tag, "_sign"},    32'(bus.sign),        32'(x[33]));
        check({tag, "_zero"},    32'(bus.out_zero),    32'(x[34]));
        check({tag, "_special"}, 32'(bus.out_special), 32'(x[35]));
    endtask

    // Issue one operation, measure latency, optionally stall the output, then complete the handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int hold);
        logic [35:0] x;
        int          lat, exp_lat, waited;
        model(a, b, sub, x, exp_lat);
        exp_q.push_back(x);
        lat_q.push_back(exp_lat);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        check({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = sub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        check({tag, "_in_ready_drop"}, 32'(bus.in_ready), 32'd0);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        x       = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        expect_outputs(tag, x);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            expect_outputs({tag, "_hold"}, x);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_after_hs"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ea, eb;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        expect_outputs("rst", 36'd0);

        run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 0);
        run_op("two_minus_1p5", 32'h40000000, 32'h3FC00000, 1'b1, 0);
        run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 0);
        run_op("far_d30",       32'h3F800000, 32'h30800000, 1'b0, 0);
        run_op("neg1_plus_half",32'hBF800000, 32'h3F000000, 1'b0, 0);
        run_op("stall5",        32'h41200000, 32'hC0400000, 1'b0, 5);
        run_op("after_stall",   32'h00000001, 32'h00400000, 1'b0, 0);

        // Reset while aligning a d=20 operation; the result must be dropped.
        bus.in_valid = 1'b1;
        bus.a        = 32'h49800000;
        bus.b        = 32'h3F800000;
        bus.op_sub   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_state",     32'(dbg_state),     32'(IDLE));
        repeat (30) @(posedge clk);
        #1 check("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
        run_op("nan_operand", 32'h7FC00000, 32'h3F800000, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            ea = $urandom_range(0, 254);
            eb = ea + $urandom_range(0, 32) - 16;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            if ($urandom_range(0, 15) == 0) ea = 255;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0]};
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
